// File: rtl/fft_radix2_iter.sv
// Iterative radix-2 DIT FFT/IFFT. Samples load bit-reversed, one shared butterfly works in place,
// results stream out in natural order with optional per-stage halving and saturation.
module fft_radix2_iter #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 16,
    parameter int unsigned TW    = 16,
    parameter int unsigned SCALE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic                inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                ovf
);
    localparam int unsigned L   = $clog2(N);
    localparam int unsigned SBW = $clog2(L);
    localparam int unsigned MW  = W + TW;
    localparam int unsigned PW  = MW + 1;
    localparam int unsigned SW  = W + 2;
    localparam logic signed [SW-1:0] MaxV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MinV = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] Rnd  = PW'(1 << (TW - 3));
    localparam real Pi      = 3.14159265358979323846;
    localparam real TwScale = real'(1 << (TW - 2));

    typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

    state_e              state_q, state_d;
    logic [L-1:0]        in_cnt_q, out_cnt_q, bfly_q;
    logic [SBW-1:0]      stage_q;
    logic                inv_q, ovf_q;
    logic signed [W-1:0] mem_re [N];
    logic signed [W-1:0] mem_im [N];

    // Twiddle ROM: cos and sin of 2*pi*k/N in Q2.(TW-2), rounded to nearest.
    logic signed [TW-1:0] rom_cos [N/2];
    logic signed [TW-1:0] rom_sin [N/2];
    for (genvar i = 0; i < N / 2; i++) begin : g_rom
        localparam real Ang  = 2.0 * Pi * real'(i) / real'(N);
        localparam real CosR = $cos(Ang) * TwScale;
        localparam real SinR = $sin(Ang) * TwScale;
        localparam int  CosI = (CosR >= 0.0) ? $rtoi(CosR + 0.5) : $rtoi(CosR - 0.5);
        localparam int  SinI = (SinR >= 0.0) ? $rtoi(SinR + 0.5) : $rtoi(SinR - 0.5);
        assign rom_cos[i] = TW'(CosI);
        assign rom_sin[i] = TW'(SinI);
    end

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int unsigned i = 0; i < L; i++) begin
            r[i] = v[L-1-i];
        end
        return r;
    endfunction

    function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v);
        if (SCALE != 0) return (v + SW'(1)) >>> 1;
        return v;
    endfunction

    function automatic logic is_sat(input logic signed [SW-1:0] v);
        return (v > MaxV) || (v < MinV);
    endfunction

    function automatic logic signed [W-1:0] clip(input logic signed [SW-1:0] v);
        if (v > MaxV) return MaxV[W-1:0];
        if (v < MinV) return MinV[W-1:0];
        return v[W-1:0];
    endfunction

    logic load_fire, out_fire, last_bfly, last_stage;

    assign in_ready   = (state_q == StLoad);
    assign out_valid  = (state_q == StUnload);
    assign load_fire  = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_bfly  = (bfly_q == L'(N / 2 - 1));
    assign last_stage = (stage_q == SBW'(L - 1));
    assign out_re     = out_valid ? mem_re[out_cnt_q] : '0;
    assign out_im     = out_valid ? mem_im[out_cnt_q] : '0;
    assign out_last   = out_valid && (out_cnt_q == L'(N - 1));
    assign ovf        = ovf_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:    if (load_fire && in_cnt_q == L'(N - 1)) state_d = StCompute;
            StCompute: if (last_bfly && last_stage) state_d = StUnload;
            StUnload:  if (out_fire && out_cnt_q == L'(N - 1)) state_d = StLoad;
            default:   state_d = StLoad;
        endcase
    end

    logic [L-1:0]         span, pos, top_addr, bot_addr;
    logic [L-2:0]         tw_idx;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0] p_re_w, p_im_w;
    logic signed [SW-1:0] p_re, p_im, t_re, t_im, u_re, u_im;
    logic signed [W-1:0]  top_re, top_im, bot_re, bot_im;
    logic                 sat_any;

    always_comb begin
        span     = L'(1) << stage_q;
        pos      = bfly_q & (span - L'(1));
        top_addr = (((bfly_q >> stage_q) << stage_q) << 1) | pos;
        bot_addr = top_addr | span;
        tw_idx   = (L-1)'(pos << (L - 1 - stage_q));
        a_re     = mem_re[top_addr];
        a_im     = mem_im[top_addr];
        b_re     = mem_re[bot_addr];
        b_im     = mem_im[bot_addr];
        // Inverse uses the conjugate twiddle: +sin instead of -sin.
        w_re     = rom_cos[tw_idx];
        w_im     = inv_q ? rom_sin[tw_idx] : -rom_sin[tw_idx];
        m_rr     = MW'(w_re) * MW'(b_re);
        m_ii     = MW'(w_im) * MW'(b_im);
        m_ri     = MW'(w_re) * MW'(b_im);
        m_ir     = MW'(w_im) * MW'(b_re);
        p_re_w   = (PW'(m_rr) - PW'(m_ii) + Rnd) >>> (TW - 2);
        p_im_w   = (PW'(m_ri) + PW'(m_ir) + Rnd) >>> (TW - 2);
        p_re     = SW'(p_re_w);
        p_im     = SW'(p_im_w);
        t_re     = scl(SW'(a_re) + p_re);
        t_im     = scl(SW'(a_im) + p_im);
        u_re     = scl(SW'(a_re) - p_re);
        u_im     = scl(SW'(a_im) - p_im);
        top_re   = clip(t_re);
        top_im   = clip(t_im);
        bot_re   = clip(u_re);
        bot_im   = clip(u_im);
        sat_any  = is_sat(t_re) | is_sat(t_im) | is_sat(u_re) | is_sat(u_im);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StLoad;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            bfly_q    <= '0;
            stage_q   <= '0;
            inv_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_fire) begin
                in_cnt_q <= in_cnt_q + L'(1);
                if (in_cnt_q == '0) begin
                    inv_q <= inv;
                    ovf_q <= 1'b0;
                end
            end
            if (state_q == StCompute) begin
                if (sat_any) ovf_q <= 1'b1;
                if (last_bfly) begin
                    bfly_q  <= '0;
                    stage_q <= last_stage ? '0 : stage_q + SBW'(1);
                end else begin
                    bfly_q <= bfly_q + L'(1);
                end
            end
            if (out_fire) out_cnt_q <= out_cnt_q + L'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_re <= '{default: '0};
            mem_im <= '{default: '0};
        end else if (load_fire) begin
            mem_re[bitrev(in_cnt_q)] <= in_re;
            mem_im[bitrev(in_cnt_q)] <= in_im;
        end else if (state_q == StCompute) begin
            mem_re[top_addr] <= top_re;
            mem_im[top_addr] <= top_im;
            mem_re[bot_addr] <= bot_re;
            mem_im[bot_addr] <= bot_im;
        end
    end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed bench: four engines (N=8/16, SCALE=0/1) sharing one clock and reset,
// with expected outputs queued at stimulus time and popped as each output is consumed.
module tb_fft_radix2_iter;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid  [4];
    logic                in_ready  [4];
    logic signed [W-1:0] in_re     [4];
    logic signed [W-1:0] in_im     [4];
    logic                inv       [4];
    logic                out_valid [4];
    logic                out_ready [4];
    logic signed [W-1:0] out_re    [4];
    logic signed [W-1:0] out_im    [4];
    logic                out_last  [4];
    logic                ovf       [4];

    // Instance g: N = 8 for g<2 else 16, SCALE = g%2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        fft_radix2_iter #(
            .N    (g < 2 ? 8 : 16),
            .W    (W),
            .TW   (16),
            .SCALE(g % 2)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_re    (in_re[g]),
            .in_im    (in_im[g]),
            .inv      (inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_re   (out_re[g]),
            .out_im   (out_im[g]),
            .out_last (out_last[g]),
            .ovf      (ovf[g])
        );
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_re_q [$];
    int exp_im_q [$];
    int src_re [16];
    int src_im [16];
    int rx_re  [16];
    int rx_im  [16];
    int orig_re [16];
    int orig_im [16];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic send_frame(input int id, input int n, input logic inv_first, input bit toggle);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1) chk("ovf_clear_on_first", int'(ovf[id]), 0);
            chk("in_ready_load", int'(in_ready[id]), 1);
            in_valid[id] = 1'b1;
            in_re[id]    = W'(src_re[i]);
            in_im[id]    = W'(src_im[i]);
            inv[id]      = (i != 0 && toggle) ? 1'($urandom_range(1)) : inv_first;
            @(posedge clk);
        end
        #1;
        in_valid[id] = 1'b0;
    endtask

    task automatic wait_latency(input int id, input int exp_c);
        int cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            if (out_valid[id]) break;
            @(posedge clk);
            cnt++;
        end
        chk("out_valid_latency", cnt, exp_c);
    endtask

    task automatic recv_frame(input int id, input int n, input int pct, input int tol,
                              input bit use_sb, input bit junk);
        int j = 0;
        int guard = 0;
        bit stalled = 0;
        int h_re = 0;
        int h_im = 0;
        int h_last = 0;
        if (junk) begin
            in_valid[id] = 1'b1;
            in_re[id]    = 16'sh5555;
            in_im[id]    = 16'sh2AAA;
        end
        while (j < n && guard < 2000) begin
            @(negedge clk);
            out_ready[id] = (int'($urandom_range(99)) < pct);
            if (out_valid[id]) begin
                chk("in_ready_unload", int'(in_ready[id]), 0);
                if (stalled) begin
                    chk("hold_re", int'(out_re[id]), h_re);
                    chk("hold_im", int'(out_im[id]), h_im);
                    chk("hold_last", int'(out_last[id]), h_last);
                end
                if (out_ready[id]) begin
                    chk("out_last", int'(out_last[id]), int'(j == n - 1));
                    rx_re[j] = int'(out_re[id]);
                    rx_im[j] = int'(out_im[id]);
                    if (use_sb) begin
                        chk("sb_depth", int'(exp_re_q.size() > 0), 1);
                        if (exp_re_q.size() > 0) begin
                            chk_tol("x_re", rx_re[j], exp_re_q.pop_front(), tol);
                            chk_tol("x_im", rx_im[j], exp_im_q.pop_front(), tol);
                        end
                    end
                    j++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    h_re    = int'(out_re[id]);
                    h_im    = int'(out_im[id]);
                    h_last  = int'(out_last[id]);
                end
            end
            @(posedge clk);
            guard++;
        end
        #1;
        chk("frame_count", j, n);
        chk("in_ready_after_unload", int'(in_ready[id]), 1);
        chk("out_valid_after_unload", int'(out_valid[id]), 0);
        out_ready[id] = 1'b0;
        in_valid[id]  = 1'b0;
    endtask

    task automatic setup_impulse(input int n);
        for (int i = 0; i < 16; i++) begin
            src_re[i] = (i == 0) ? 32'h1000 : 0;
            src_im[i] = 0;
        end
        for (int k = 0; k < n; k++) begin
            exp_re_q.push_back(32'h1000);
            exp_im_q.push_back(0);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_re[i]     = '0;
            in_im[i]     = '0;
            inv[i]       = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_in_ready", int'(in_ready[i]), 1);
            chk("reset_out_valid", int'(out_valid[i]), 0);
            chk("reset_out_last", int'(out_last[i]), 0);
            chk("reset_ovf", int'(ovf[i]), 0);
            chk("reset_out_re", int'(out_re[i]), 0);
            chk("reset_out_im", int'(out_im[i]), 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Impulse, N=8, SCALE=0
        setup_impulse(8);
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 100, 0, 1'b1, 1'b0);
        chk("impulse_ovf", int'(ovf[0]), 0);

        // DC, N=8, SCALE=1
        for (int i = 0; i < 16; i++) begin
            src_re[i] = 32'h0800;
            src_im[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            exp_re_q.push_back((k == 0) ? 32'h0800 : 0);
            exp_im_q.push_back(0);
        end
        send_frame(1, 8, 1'b0, 1'b0);
        wait_latency(1, 12);
        recv_frame(1, 8, 100, 0, 1'b1, 1'b0);

        // Round trip, N=16: forward SCALE=0 then inverse SCALE=1, inv jittered mid-frame
        for (int i = 0; i < 16; i++) begin
            src_re[i]  = int'($urandom_range(2046)) - 1023;
            src_im[i]  = int'($urandom_range(2046)) - 1023;
            orig_re[i] = src_re[i];
            orig_im[i] = src_im[i];
        end
        send_frame(2, 16, 1'b0, 1'b1);
        wait_latency(2, 32);
        recv_frame(2, 16, 100, 0, 1'b0, 1'b0);
        chk("fwd_ovf", int'(ovf[2]), 0);
        for (int i = 0; i < 16; i++) begin
            src_re[i] = rx_re[i];
            src_im[i] = rx_im[i];
            exp_re_q.push_back(orig_re[i]);
            exp_im_q.push_back(orig_im[i]);
        end
        send_frame(3, 16, 1'b1, 1'b1);
        wait_latency(3, 32);
        recv_frame(3, 16, 100, 2, 1'b1, 1'b0);

        // Overflow, N=8, SCALE=0; ovf must survive until the next frame's first accept
        for (int i = 0; i < 16; i++) begin
            src_re[i] = 32'h7FFF;
            src_im[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            exp_re_q.push_back((k == 0) ? 32'h7FFF : 0);
            exp_im_q.push_back(0);
        end
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 100, 0, 1'b1, 1'b0);
        chk("ovf_set", int'(ovf[0]), 1);
        repeat (3) @(negedge clk);
        chk("ovf_hold_idle", int'(ovf[0]), 1);
        setup_impulse(8);
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 100, 0, 1'b1, 1'b0);

        // Backpressure at 30% ready, with in_valid held high through unload
        setup_impulse(8);
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 30, 0, 1'b1, 1'b1);
        setup_impulse(8);
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 100, 0, 1'b1, 1'b0);

        // Reset during compute edge 5 of 12
        for (int i = 0; i < 16; i++) begin
            src_re[i] = (i == 0) ? 32'h1000 : 0;
            src_im[i] = 0;
        end
        send_frame(0, 8, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_in_ready", int'(in_ready[0]), 1);
        chk("midreset_out_valid", int'(out_valid[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("no_partial_frame", seen, 0);
        setup_impulse(8);
        send_frame(0, 8, 1'b0, 1'b0);
        wait_latency(0, 12);
        recv_frame(0, 8, 100, 0, 1'b1, 1'b0);
        chk("sb_drained", exp_re_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_radix2_iter.md
# fft_radix2_iter

Parametrised N-point radix-2 decimation-in-time FFT/IFFT engine for the VLSI-architecture datapath. It is the generalised successor of the fixed 8-point pipelined FFT. Complex samples are accepted one per cycle under a valid/ready handshake. The block computes the transform in place with one shared butterfly, then streams results out in natural order. It adds runtime inverse mode, per-stage scaling, saturation and an overflow flag.

## Interface
- N, 8: transform length, power of two, 4..1024; L = log2(N) stages
- W, 16: sample width, signed two's complement, per real/imag part
- TW, 16: twiddle width, signed, TW-2 fractional bits (Q2.(TW-2))
- SCALE, 1: 1 = every butterfly output divided by 2 with rounding; 0 = no scaling
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_re, in_im  in  W each  input sample
- inv  in  1  inverse transform select; sampled with the first sample of a frame
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output sample
- out_re, out_im  out  W each  output sample X[k], k ascending
- out_last  out  1  high with X[N-1]
- ovf  out  1  sticky saturation flag for the current frame

## Operation
- Storage: N-entry complex register array. Each input sample n is written to address bitrev(n).
- States:
  - LOAD: in_ready=1; accept on in_valid&in_ready; input counter 0..N-1. Acceptance of sample 0 latches inv and clears ovf. Acceptance of sample N-1 goes to COMPUTE.
  - COMPUTE: in_ready=0; stage s=0..L-1; butterfly b=0..N/2-1, one butterfly per edge.
    - span=2^s, pos=b mod span, top=(b/span)*2*span+pos, bot=top+span, k=pos*N/(2*span).
    - The last butterfly of stage L-1 goes to UNLOAD.
  - UNLOAD: out_valid=1; data is array[j] for output counter j; j advances on out_valid&out_ready. The handshake at j=N-1 goes to LOAD.
- Twiddle: W_N^k = cos(2πk/N) - j·sin(2πk/N), rounded to nearest in Q2.(TW-2), from a ROM of N/2 entries built at elaboration. The inverse transform uses the conjugate.
- Butterfly arithmetic: p = w·B uses full-precision products. p is rounded by adding 2^(TW-3) and arithmetic shift right by TW-2. Then A' = A+p and B' = A-p at W+2 bits.
  - SCALE=1: add 1, then arithmetic shift right by 1.
  - Saturate each part to [-2^(W-1), 2^(W-1)-1]. Any saturation sets ovf.
- Inverse transform with SCALE=1 yields the 1/N-normalised IDFT. No conjugation of data is needed.
- inv is ignored except at acceptance of sample 0. in_valid is ignored outside LOAD.
- ovf holds through UNLOAD and until sample 0 of the next frame is accepted.

## Timing
- Reset values: state=LOAD, counters=0, in_ready=1, out_valid=0, out_last=0, ovf=0. out_re, out_im and the array are all 0.
- C = (N/2)·L compute cycles (N=8: 12).
- out_valid rises exactly C edges after the edge that accepts input sample N-1.
- Minimum frame period is N + C + N cycles. Frames do not overlap: in_ready is 0 from the edge after the last accepted input until the edge after the last output handshake.
- out_re, out_im and out_last are stable while out_valid=1 and out_ready=0.
- Any reset assertion, including mid-COMPUTE or mid-UNLOAD, returns the block to reset values immediately. No partial frame is emitted afterwards.
- Simultaneous in_valid during UNLOAD: ignored, no acceptance.

## Test plan
- Impulse, N=8, W=16, SCALE=0: x[0]=0x1000, all other inputs 0 -> all eight outputs re=0x1000, im=0; ovf=0; out_valid 12 edges after the last accept.
- DC, SCALE=1: all x=0x0800+0j -> X[0]=0x0800+0j; X[1..7]=0; out_last only with X[7].
- Round trip, N=16, SCALE=0 then inv=1, SCALE=1: take a random frame with |x|<0x0400 and feed its forward output back through the inverse -> each output within ±2 LSB of original x; inv toggled mid-frame has no effect.
- Overflow, SCALE=0: all x=0x7FFF+0j -> X[0]=0x7FFF, ovf=1; ovf clears on the next frame's first accept.
- Backpressure: out_ready random at 30% duty -> exactly N outputs in order, values held stable while stalled, in_ready=0 until the final handshake.
- Reset mid-COMPUTE (edge 5 of 12) -> in_ready=1 and out_valid=0 immediately; the next full impulse frame produces correct results.
